// File: rtl/gol_step_scheduler.sv
// Generation sequencer for the Game of Life array: turns run/step/seed requests into
// single-cycle cell_step / cell_load enables committed only at the start of vertical sync.
module gol_step_scheduler #(
    parameter int CLK_HZ = 25000000,
    parameter int CNT_W  = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             run_en,
    input  logic [3:0]       speed,
    input  logic             step_req,
    input  logic             seed_req,
    input  logic             vs,
    output logic             cell_step,
    output logic             cell_load,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] gen_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ARMED  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_step_sync;
    logic             r_step_prev;
    logic [1:0]       r_seed_sync;
    logic             r_seed_prev;
    logic             r_vs_q;
    logic [31:0]      r_tick_cnt;
    logic             r_load_pend;
    logic             r_overrun;
    logic [CNT_W-1:0] r_gen_count;
    logic             r_cell_step;
    logic             r_cell_load;

    logic             w_step_ev;
    logic             w_seed_ev;
    logic             w_vs_fall;
    logic [31:0]      w_period;
    logic [31:0]      w_limit;
    logic             w_tick;
    logic             w_cnt_en;
    logic             w_do_step;
    logic             w_do_load;
    logic             w_drop_tick;
    logic             w_busy;

    assign w_step_ev = r_step_sync[1] & ~r_step_prev;
    assign w_seed_ev = r_seed_sync[1] & ~r_seed_prev;
    assign w_vs_fall = r_vs_q & ~vs;

    // A zero period (speed too large for CLK_HZ) degrades to a tick every cycle.
    assign w_period = 32'(CLK_HZ) >> speed;
    assign w_limit  = (w_period == 32'd0) ? 32'd0 : w_period - 32'd1;
    assign w_tick   = w_cnt_en & (r_tick_cnt >= w_limit);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= PAUSED;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            PAUSED: begin
                if (w_seed_ev)       w_next_state = ARMED;
                else if (run_en)     w_next_state = RUN;
                else if (w_step_ev)  w_next_state = ARMED;
            end
            RUN: begin
                if (w_seed_ev)       w_next_state = ARMED;
                else if (!run_en)    w_next_state = PAUSED;
                else if (w_tick)     w_next_state = ARMED;
            end
            ARMED: begin
                if (w_vs_fall)       w_next_state = COMMIT;
            end
            COMMIT: begin
                if (w_seed_ev)       w_next_state = ARMED;
                else if (run_en)     w_next_state = RUN;
                else                 w_next_state = PAUSED;
            end
            default:                 w_next_state = PAUSED;
        endcase
    end

    // The tick counter keeps running while a free-run step waits in ARMED, so
    // periods shorter than a frame show up as dropped ticks (overrun).
    always_comb begin
        w_cnt_en    = (r_state == RUN) | ((r_state == ARMED) & run_en);
        w_do_load   = (r_state == COMMIT) & r_load_pend;
        w_do_step   = (r_state == COMMIT) & ~r_load_pend;
        w_drop_tick = (r_state == ARMED) & w_tick;
        w_busy      = (r_state == ARMED) | r_load_pend;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_step_sync <= 2'b00;
            r_step_prev <= 1'b0;
            r_seed_sync <= 2'b00;
            r_seed_prev <= 1'b0;
            r_vs_q      <= 1'b1;
        end else begin
            r_step_sync <= {r_step_sync[0], step_req};
            r_step_prev <= r_step_sync[1];
            r_seed_sync <= {r_seed_sync[0], seed_req};
            r_seed_prev <= r_seed_sync[1];
            r_vs_q      <= vs;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tick_cnt  <= 32'd0;
            r_load_pend <= 1'b0;
            r_overrun   <= 1'b0;
            r_gen_count <= '0;
            r_cell_step <= 1'b0;
            r_cell_load <= 1'b0;
        end else begin
            if (!w_cnt_en || w_tick) r_tick_cnt <= 32'd0;
            else                     r_tick_cnt <= r_tick_cnt + 32'd1;

            // A seed arriving in the commit cycle itself must survive the clear.
            if (w_seed_ev)      r_load_pend <= 1'b1;
            else if (w_do_load) r_load_pend <= 1'b0;

            if (w_do_load)        r_overrun <= 1'b0;
            else if (w_drop_tick) r_overrun <= 1'b1;

            if (w_do_load)      r_gen_count <= '0;
            else if (w_do_step) r_gen_count <= r_gen_count + CNT_W'(1);

            r_cell_step <= w_do_step;
            r_cell_load <= w_do_load;
        end
    end

    assign cell_step = r_cell_step;
    assign cell_load = r_cell_load;
    assign busy      = w_busy;
    assign overrun   = r_overrun;
    assign gen_count = r_gen_count;
    assign state     = r_state;

endmodule

// File: tb/tb_gol_step_scheduler.sv
// Bench for gol_step_scheduler: scripted frames with a scoreboard of expected
// enable pulses (kind + generation count) popped whenever the DUT pulses.
module tb_gol_step_scheduler;

  logic       Clk;
  logic       Reset_n;
  logic       run_en;
  logic [3:0] speed;
  logic       step_req;
  logic       seed_req;
  logic       vs;
  logic       cell_step;
  logic       cell_load;
  logic       busy;
  logic       overrun;
  logic [3:0] gen_count;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];
  logic [3:0] exp_gen = 4'd0;
  logic       prev_pulse = 1'b0;

  gol_step_scheduler #(.CLK_HZ(1000), .CNT_W(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .run_en(run_en), .speed(speed),
    .step_req(step_req), .seed_req(seed_req), .vs(vs),
    .cell_step(cell_step), .cell_load(cell_load), .busy(busy),
    .overrun(overrun), .gen_count(gen_count), .state(state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push_step();
    exp_gen = exp_gen + 4'd1;
    exp_q.push_back({2'b01, exp_gen});
  endtask

  task automatic push_load();
    exp_gen = 4'd0;
    exp_q.push_back({2'b10, 4'd0});
  endtask

  task automatic pulse_step();
    step_req = 1'b1;
    cycles(3);
    check("step_arm", state, 2);
    step_req = 1'b0;
    cycles(4);
  endtask

  task automatic vs_fall();
    vs = 1'b0;
    cycles(4);
    vs = 1'b1;
    cycles(4);
  endtask

  task automatic run_frame();
    cycles(396);
    check("run_armed", state, 2);
    push_step();
    vs = 1'b0;
    cycles(4);
    vs = 1'b1;
  endtask

  // scoreboard
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (cell_step | cell_load) begin
        check("both_high", {31'b0, cell_step & cell_load}, 0);
        check("back2back", {31'b0, prev_pulse}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {26'b0, cell_load, cell_step, gen_count}, 0);
        end else begin
          check("pulse", {26'b0, cell_load, cell_step, gen_count}, {26'b0, exp_q.pop_front()});
        end
      end
      prev_pulse = cell_step | cell_load;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    Reset_n = 1'b0; run_en = 1'b0; speed = 4'd0;
    step_req = 1'b0; seed_req = 1'b0; vs = 1'b1;

    // reset with vs toggling
    for (int i = 0; i < 20; i++) begin
      vs = i[2];
      cycles(1);
      check("rst_enables", {30'b0, cell_step, cell_load}, 0);
    end
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_gen", gen_count, 0);
    check("rst_state", state, 0);
    vs = 1'b1;
    cycles(2);
    Reset_n = 1'b1;
    cycles(2);

    // single step
    step_req = 1'b1;
    cycles(2);
    check("pre_arm_state", state, 0);
    cycles(1);
    check("arm_state", state, 2);
    check("arm_busy", busy, 1);
    cycles(7);
    step_req = 1'b0;
    cycles(100);
    check("armed_hold", state, 2);
    push_step();
    vs = 1'b0;
    cycles(1);
    check("commit_state", state, 3);
    check("step_not_early", cell_step, 0);
    cycles(1);
    check("step_pulse", cell_step, 1);
    check("after_commit_state", state, 0);
    cycles(1);
    check("step_one_cycle", cell_step, 0);
    vs = 1'b1;
    cycles(20);
    vs_fall();
    check("single_gen", gen_count, 1);
    check("single_idle", busy, 0);

    // load beats step
    step_req = 1'b1; seed_req = 1'b1;
    cycles(5);
    step_req = 1'b0; seed_req = 1'b0;
    cycles(5);
    check("load_armed", state, 2);
    check("load_busy", busy, 1);
    push_load();
    vs = 1'b0;
    cycles(2);
    check("load_pulse", cell_load, 1);
    check("load_no_step", cell_step, 0);
    check("load_gen", gen_count, 0);
    cycles(2);
    vs = 1'b1;
    cycles(4);
    check("load_done_busy", busy, 0);

    // 16 steps wrap gen_count
    for (int i = 0; i < 16; i++) begin
      pulse_step();
      push_step();
      vs_fall();
    end
    check("wrap_gen", gen_count, 0);

    // free run, period 250 < frame 400
    speed = 4'd2;
    run_en = 1'b1;
    cycles(1);
    check("run_state", state, 1);
    for (int i = 0; i < 5; i++) run_frame();
    check("free_no_overrun", overrun, 0);

    // overrun, period 62 < frame 400
    speed = 4'd4;
    for (int i = 0; i < 3; i++) run_frame();
    check("overrun_set", overrun, 1);
    cycles(50);
    seed_req = 1'b1;
    cycles(3);
    seed_req = 1'b0;
    cycles(300);
    check("seed_busy", busy, 1);
    push_load();
    vs = 1'b0;
    cycles(1);
    check("seed_commit", state, 3);
    cycles(1);
    check("seed_load", cell_load, 1);
    check("overrun_clear", overrun, 0);
    check("seed_gen", gen_count, 0);
    cycles(2);
    vs = 1'b1;

    // drop run_en while ARMED
    cycles(100);
    check("stop_armed", state, 2);
    run_en = 1'b0;
    cycles(5);
    check("stop_still_armed", state, 2);
    push_step();
    vs = 1'b0;
    cycles(1);
    check("stop_commit", state, 3);
    cycles(1);
    check("stop_step", cell_step, 1);
    check("stop_paused", state, 0);
    cycles(2);
    vs = 1'b1;
    cycles(4);
    check("stop_gen", gen_count, 1);

    // reset while ARMED loses the pending step
    pulse_step();
    Reset_n = 1'b0;
    #2;
    check("midrst_state", state, 0);
    check("midrst_busy", busy, 0);
    check("midrst_gen", gen_count, 0);
    cycles(3);
    Reset_n = 1'b1;
    cycles(3);
    vs_fall();
    check("midrst_after_state", state, 0);
    check("midrst_after_gen", gen_count, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
